mem_access_unit: RTL and testbench

M-stage data-memory access unit for the pipelined MIPS core, sitting between the M pipeline register and the external data-memory port. It registers one load/store request per cycle, drives the byte-enable data bus, and aligns and extends load data. It detects address errors and delivers load results, exceptions and access counts to the W stage one cycle after the memory access.

---
 rtl/mem_access_unit.sv | 237 +++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage data-memory access unit.
//   One load/store request per cycle is captured into the M register. The
//   memory port (address, lane-replicated store data, byte enables) is
//   driven combinationally from that register. Load data is aligned and
//   extended, address errors are classified, and the result moves to the W
//   register one edge later. Saturating counters track completed accesses.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-low reset
//   req_*                 request from the E stage (valid, op, addr, wdata, pc, rd)
//   stall, flush          stall blocks acceptance; flush kills the M entry
//   m_data_addr/wdata/byteen, m_inst_addr   memory port driven from M
//   m_data_rdata          combinational read data for word m_data_addr>>2
//   w_*                   W-stage result (valid, we, rd, data, pc, exc, code, badvaddr)
//   load_cnt, store_cnt   saturating completed-access counters

// Per-byte-lane store logic: decides whether this lane is written and which
// source byte lands on it.
module mem_access_unit_lane #(
   parameter int LANE  = 0,
   parameter int VEC_W = 8
) (
   input  logic             be_en,    // error-free, live store in M
   input  logic             dat_en,   // any valid store in M
   input  logic             st_w,
   input  logic             st_h,
   input  logic             st_b,
   input  logic [1:0]       addr_lo,
   input  logic [VEC_W-1:0] w_byte,   // byte LANE of the source word
   input  logic [VEC_W-1:0] h_byte,   // byte LANE%2 of the source word
   input  logic [VEC_W-1:0] b_byte,   // byte 0 of the source word
   output logic             be,
   output logic [VEC_W-1:0] wbyte
);
   localparam logic [1:0] LID = 2'(LANE);

   logic sel;

   always_comb begin
      sel   = 1'b0;
      wbyte = '0;
      if (st_w)      sel = 1'b1;
      else if (st_h) sel = (addr_lo[1] == LID[1]);
      else if (st_b) sel = (addr_lo == LID);
      be = be_en & sel;
      if (dat_en) begin
         if (st_w)      wbyte = w_byte;
         else if (st_h) wbyte = h_byte;
         else if (st_b) wbyte = b_byte;
      end
   end
endmodule

module mem_access_unit #(
   parameter int DM_WORDS = 4096,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   input  logic [3:0]       req_op,
   input  logic [31:0]      req_addr,
   input  logic [31:0]      req_wdata,
   input  logic [31:0]      req_pc,
   input  logic [4:0]       req_rd,
   input  logic             stall,
   input  logic             flush,
   output logic [31:0]      m_data_addr,
   output logic [31:0]      m_data_wdata,
   output logic [3:0]       m_data_byteen,
   output logic [31:0]      m_inst_addr,
   input  logic [31:0]      m_data_rdata,
   output logic             w_valid,
   output logic             w_we,
   output logic [4:0]       w_rd,
   output logic [31:0]      w_data,
   output logic [31:0]      w_pc,
   output logic             w_exc,
   output logic [4:0]       w_exc_code,
   output logic [31:0]      w_badvaddr,
   output logic [CNT_W-1:0] load_cnt,
   output logic [CNT_W-1:0] store_cnt
);
   localparam int          NUM_LANES = 4;
   localparam int          VEC_W     = 8;
   localparam int          STAGES    = 1;
   // 33 bits so the limit itself is representable for any depth.
   localparam logic [32:0] DM_BYTES  = 33'(DM_WORDS) << 2;

   typedef enum logic [3:0] {
      OP_NONE = 4'd0,
      OP_LW   = 4'd1,
      OP_LH   = 4'd2,
      OP_LHU  = 4'd3,
      OP_LB   = 4'd4,
      OP_LBU  = 4'd5,
      OP_SW   = 4'd6,
      OP_SH   = 4'd7,
      OP_SB   = 4'd8
   } op_e;

   typedef struct packed {
      op_e         op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] pc;
      logic [4:0]  rd;
   } m_req_t;

   typedef struct packed {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [31:0] pc;
      logic        exc;
      logic [4:0]  exc_code;
      logic [31:0] badvaddr;
   } w_rsp_t;

   // vld_pipe[0]: M entry valid, vld_pipe[1]: W entry valid
   logic [STAGES:0] vld_pipe;
   m_req_t          m_q;
   w_rsp_t          w_q;

   logic accept;
   logic is_load, is_store, sz_w, sz_h;
   logic misalign, oob, addr_err;
   logic live, ld_ok, st_done, st_en, st_dat;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;
   logic [NUM_LANES-1:0][VEC_W-1:0] wdata_lanes;

   assign accept = req_valid && !stall && (req_op >= 4'd1) && (req_op <= 4'd8);

   // ---------------- M-stage decode ----------------
   always_comb begin
      is_load  = m_q.op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
      is_store = m_q.op inside {OP_SW, OP_SH, OP_SB};
      sz_w     = m_q.op inside {OP_LW, OP_SW};
      sz_h     = m_q.op inside {OP_LH, OP_LHU, OP_SH};
      misalign = (sz_w && (m_q.addr[1:0] != 2'b00)) || (sz_h && m_q.addr[0]);
      oob      = {1'b0, m_q.addr} >= DM_BYTES;
      addr_err = misalign || oob;
      live     = vld_pipe[0] && !flush;
      ld_ok    = live && is_load && !addr_err;
      st_done  = live && is_store && !addr_err;
      // Gating with reset keeps a store sitting in M at a reset edge from
      // reaching memory.
      st_en    = st_done && reset;
      st_dat   = vld_pipe[0] && is_store;
   end

   // ---------------- store lanes ----------------
   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      mem_access_unit_lane #(.LANE(i), .VEC_W(VEC_W)) u_lane (
         .be_en   (st_en),
         .dat_en  (st_dat),
         .st_w    (m_q.op == OP_SW),
         .st_h    (m_q.op == OP_SH),
         .st_b    (m_q.op == OP_SB),
         .addr_lo (m_q.addr[1:0]),
         .w_byte  (m_q.wdata[VEC_W*i +: VEC_W]),
         .h_byte  (m_q.wdata[VEC_W*(i%2) +: VEC_W]),
         .b_byte  (m_q.wdata[VEC_W-1:0]),
         .be      (m_data_byteen[i]),
         .wbyte   (wdata_lanes[i])
      );
   end

   assign m_data_wdata = wdata_lanes;
   assign m_data_addr  = m_q.addr;
   assign m_inst_addr  = m_q.pc;

   // ---------------- load alignment ----------------
   always_comb begin
      ld_byte = m_data_rdata[{m_q.addr[1:0], 3'b000} +: 8];
      ld_half = m_q.addr[1] ? m_data_rdata[31:16] : m_data_rdata[15:0];
      ld_data = m_data_rdata;
      case (m_q.op)
         OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
         OP_LHU:  ld_data = {16'h0000, ld_half};
         OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
         OP_LBU:  ld_data = {24'h000000, ld_byte};
         default: ld_data = m_data_rdata;
      endcase
   end

   // ---------------- M and W registers ----------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         vld_pipe <= '0;
         m_q      <= '0;
         w_q      <= '0;
      end else begin
         // Bubbles only clear the valid bit; the fields hold so the memory
         // address outputs stay stable.
         vld_pipe[0] <= accept;
         if (accept) begin
            m_q.op    <= op_e'(req_op);
            m_q.addr  <= req_addr;
            m_q.wdata <= req_wdata;
            m_q.pc    <= req_pc;
            m_q.rd    <= req_rd;
         end
         vld_pipe[1]  <= live;
         w_q.we       <= ld_ok && (m_q.rd != 5'd0);
         w_q.rd       <= m_q.rd;
         w_q.data     <= (ld_ok && (m_q.rd != 5'd0)) ? ld_data : 32'h0;
         w_q.pc       <= m_q.pc;
         w_q.exc      <= live && addr_err;
         w_q.exc_code <= (live && addr_err) ? (is_load ? 5'd4 : 5'd5) : 5'd0;
         w_q.badvaddr <= m_q.addr;
      end
   end

   // ---------------- saturating counters ----------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         load_cnt  <= '0;
         store_cnt <= '0;
      end else begin
         if (ld_ok && (load_cnt != '1))
            load_cnt <= load_cnt + CNT_W'(1);
         if (st_done && (store_cnt != '1))
            store_cnt <= store_cnt + CNT_W'(1);
      end
   end

   assign w_valid    = vld_pipe[1];
   assign w_we       = w_q.we;
   assign w_rd       = w_q.rd;
   assign w_data     = w_q.data;
   assign w_pc       = w_q.pc;
   assign w_exc      = w_q.exc;
   assign w_exc_code = w_q.exc_code;
   assign w_badvaddr = w_q.badvaddr;
endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
   localparam int          DM_WORDS = 4096;
   localparam logic [31:0] DM_BYTES = DM_WORDS * 4;
   localparam bit [3:0] LW = 1, LH = 2, LHU = 3, LB = 4, LBU = 5, SW = 6, SH = 7, SB = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0, stall = 1'b0, flush = 1'b0;
   logic [3:0]  req_op = '0;
   logic [31:0] req_addr = '0, req_wdata = '0, req_pc = '0;
   logic [4:0]  req_rd = '0;
   logic [31:0] m_data_addr, m_data_wdata, m_inst_addr, m_data_rdata;
   logic [3:0]  m_data_byteen;
   logic        w_valid, w_we, w_exc;
   logic [4:0]  w_rd, w_exc_code;
   logic [31:0] w_data, w_pc, w_badvaddr;
   logic [15:0] load_cnt, store_cnt;
   // second instance with 2-bit counters, driven by the same stimulus
   logic [31:0] s_addr, s_wdata, s_iaddr;
   logic [3:0]  s_byteen;
   logic        s_valid, s_we, s_exc;
   logic [4:0]  s_rd, s_code;
   logic [31:0] s_data, s_pc, s_badv;
   logic [1:0]  s_load_cnt, s_store_cnt;

   always #5 clk = ~clk;

   mem_access_unit #(.DM_WORDS(DM_WORDS), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc), .req_rd(req_rd),
      .stall(stall), .flush(flush), .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
      .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr), .m_data_rdata(m_data_rdata),
      .w_valid(w_valid), .w_we(w_we), .w_rd(w_rd), .w_data(w_data), .w_pc(w_pc),
      .w_exc(w_exc), .w_exc_code(w_exc_code), .w_badvaddr(w_badvaddr),
      .load_cnt(load_cnt), .store_cnt(store_cnt));

   mem_access_unit #(.DM_WORDS(DM_WORDS), .CNT_W(2)) u_sat (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc), .req_rd(req_rd),
      .stall(stall), .flush(flush), .m_data_addr(s_addr), .m_data_wdata(s_wdata),
      .m_data_byteen(s_byteen), .m_inst_addr(s_iaddr), .m_data_rdata(m_data_rdata),
      .w_valid(s_valid), .w_we(s_we), .w_rd(s_rd), .w_data(s_data), .w_pc(s_pc),
      .w_exc(s_exc), .w_exc_code(s_code), .w_badvaddr(s_badv),
      .load_cnt(s_load_cnt), .store_cnt(s_store_cnt));

   // data memory: combinational read, byte-enable write, cleared on reset
   logic [31:0] tb_mem [DM_WORDS];
   assign m_data_rdata = tb_mem[m_data_addr[13:2]];
   always @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DM_WORDS; i++) tb_mem[i] <= '0;
      end else begin
         for (int b = 0; b < 4; b++)
            if (m_data_byteen[b]) tb_mem[m_data_addr[13:2]][8*b +: 8] <= m_data_wdata[8*b +: 8];
      end
   end

   // ---------------- reference model ----------------
   typedef struct {
      bit        v;
      bit [3:0]  op;
      bit [31:0] addr, wdata, pc;
      bit [4:0]  rd;
   } req_t;

   typedef struct {
      bit        rst, valid, we, exc;
      bit [4:0]  rd, code;
      bit [31:0] data, pc, badv;
      int        lcnt, scnt, lsat, ssat;
   } exp_t;

   exp_t      exp_q[$];
   exp_t      zero_e;
   req_t      pend;
   byte unsigned mm [DM_WORDS*4];
   int        lc, sc, lsat, ssat;
   bit [31:0] pc_ctr = 32'h0040_0000;
   int        checks = 0, errors = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic int op_size(bit [3:0] op);
      if (op == LW || op == SW) return 4;
      if (op == LH || op == LHU || op == SH) return 2;
      return 1;
   endfunction

   // One clock cycle: drive the new request, then resolve the entry sitting in M.
   task automatic cycle(input bit v, input bit [3:0] op, input bit [31:0] addr,
                        input bit [31:0] wd, input bit [4:0] rd, input bit stl, input bit fl);
      exp_t      e;
      bit [3:0]  exp_be;
      bit [31:0] word, exp_wd;
      bit        err, ld, st;
      int        sz;
      @(negedge clk);
      reset = 1'b1; req_valid = v; req_op = op; req_addr = addr; req_wdata = wd;
      req_pc = pc_ctr; req_rd = rd; stall = stl; flush = fl;
      #1;
      e = zero_e; exp_be = '0;
      ld = pend.v && pend.op >= LW && pend.op <= LBU;
      st = pend.v && pend.op >= SW && pend.op <= SB;
      sz = op_size(pend.op);
      err = pend.addr >= DM_BYTES || (pend.addr % sz) != 0;
      if (pend.v && !fl) begin
         e.valid = 1; e.pc = pend.pc;
         if (err) begin
            e.exc = 1; e.code = ld ? 5'd4 : 5'd5; e.badv = pend.addr;
         end else if (ld) begin
            word = 0;
            for (int i = 0; i < sz; i++) word |= 32'(mm[pend.addr + i]) << (8*i);
            if ((pend.op == LH || pend.op == LB) && word[8*sz-1]) word |= ~((32'd1 << (8*sz)) - 1);
            e.we = pend.rd != 0; e.rd = pend.rd; e.data = e.we ? word : 0;
            lc = (lc == 65535) ? lc : lc + 1;
            lsat = (lsat == 3) ? 3 : lsat + 1;
         end else begin
            for (int i = 0; i < sz; i++) begin
               mm[pend.addr + i] = 8'(pend.wdata >> (8*i));
               exp_be[(pend.addr % 4) + i] = 1'b1;
            end
            sc = (sc == 65535) ? sc : sc + 1;
            ssat = (ssat == 3) ? 3 : ssat + 1;
         end
      end
      chk("byteen", 32'(m_data_byteen), 32'(exp_be));
      if (pend.v) begin
         chk("m_data_addr", m_data_addr, pend.addr);
         chk("m_inst_addr", m_inst_addr, pend.pc);
      end
      if (st && !fl && !err) begin
         exp_wd = (sz == 4) ? pend.wdata : (sz == 2) ? {2{pend.wdata[15:0]}} : {4{pend.wdata[7:0]}};
         chk("m_data_wdata", m_data_wdata, exp_wd);
      end
      if (ld) chk("wdata_load", m_data_wdata, 32'h0);
      e.lcnt = lc; e.scnt = sc; e.lsat = lsat; e.ssat = ssat;
      exp_q.push_back(e);
      if (v && !stl && op >= 1 && op <= 8) begin
         pend.v = 1; pend.op = op; pend.addr = addr; pend.wdata = wd; pend.pc = pc_ctr; pend.rd = rd;
      end else begin
         pend.v = 0;
      end
      pc_ctr += 4;
   endtask

   task automatic do_reset();
      exp_t e;
      @(negedge clk);
      reset = 1'b0; req_valid = 1'b0; stall = 1'b0; flush = 1'b0;
      #1;
      chk("byteen_in_reset", 32'(m_data_byteen), 32'h0);
      for (int i = 0; i < DM_WORDS*4; i++) mm[i] = 0;
      lc = 0; sc = 0; lsat = 0; ssat = 0;
      pend.v = 0; pend.op = 0; pend.addr = 0; pend.wdata = 0; pend.pc = 0; pend.rd = 0;
      e = zero_e; e.rst = 1;
      exp_q.push_back(e);
   endtask

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("w_valid", 32'(w_valid), 32'(e.valid));
            chk("w_we", 32'(w_we), 32'(e.we));
            chk("w_exc", 32'(w_exc), 32'(e.exc));
            chk("w_data", w_data, e.data);
            if (e.we) chk("w_rd", 32'(w_rd), 32'(e.rd));
            if (e.valid) chk("w_pc", w_pc, e.pc);
            if (e.exc) begin
               chk("w_exc_code", 32'(w_exc_code), 32'(e.code));
               chk("w_badvaddr", w_badvaddr, e.badv);
            end
            chk("load_cnt", 32'(load_cnt), 32'(e.lcnt));
            chk("store_cnt", 32'(store_cnt), 32'(e.scnt));
            chk("load_cnt_sat", 32'(s_load_cnt), 32'(e.lsat));
            chk("store_cnt_sat", 32'(s_store_cnt), 32'(e.ssat));
            if (e.rst) begin
               chk("rst_addr", m_data_addr, 32'h0);
               chk("rst_iaddr", m_inst_addr, 32'h0);
               chk("rst_wdata", m_data_wdata, 32'h0);
               chk("rst_wpc", w_pc, 32'h0);
               chk("rst_badv", w_badvaddr, 32'h0);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      bit [31:0] a;
      int        r;
      repeat (3) do_reset();
      // word store / load
      cycle(1, SW, 32'h10, 32'h12345678, 0, 0, 0);
      cycle(1, LW, 32'h10, 0, 8, 0, 0);
      // byte store, signed and unsigned byte loads
      cycle(1, SB, 32'h21, 32'h000000AB, 0, 0, 0);
      cycle(1, LB, 32'h21, 0, 5, 0, 0);
      cycle(1, LBU, 32'h21, 0, 6, 0, 0);
      // half store, signed and unsigned half loads
      cycle(1, SH, 32'h32, 32'h00008001, 0, 0, 0);
      cycle(1, LH, 32'h32, 0, 3, 0, 0);
      cycle(1, LHU, 32'h32, 0, 4, 0, 0);
      // address errors
      cycle(1, LW, 32'h13, 0, 7, 0, 0);
      cycle(1, SH, 32'h05, 32'hFFFF, 0, 0, 0);
      cycle(1, SW, 32'h4000, 32'h1, 0, 0, 0);
      // load to r0 is not written back
      cycle(1, LW, 32'h10, 0, 0, 0, 0);
      // flushed store, stalled store, then read both locations back
      cycle(1, SW, 32'h40, 32'hDEADBEEF, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 1);
      cycle(1, SW, 32'h44, 32'hCAFEF00D, 0, 1, 0);
      cycle(1, LW, 32'h40, 0, 9, 0, 0);
      cycle(1, LW, 32'h44, 0, 10, 0, 0);
      // stall and flush together
      cycle(1, SW, 32'h48, 32'h11112222, 0, 0, 0);
      cycle(1, SW, 32'h48, 32'h33334444, 0, 1, 1);
      cycle(1, LW, 32'h48, 0, 11, 0, 0);
      // store in M at a reset edge
      cycle(1, SW, 32'h50, 32'h55AA55AA, 0, 0, 0);
      do_reset();
      do_reset();
      // counter saturation on the 2-bit instance
      for (int i = 0; i < 5; i++) cycle(1, LW, 32'(i * 4), 0, 5'(i + 1), 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
      // randomized traffic
      for (int n = 0; n < 500; n++) begin
         r = $urandom_range(0, 9);
         if (r == 0) a = DM_BYTES + $urandom_range(0, 255);
         else a = 32'($urandom_range(0, 15) * 4) + ((r < 5) ? 32'd0 : 32'($urandom_range(0, 3)));
         cycle($urandom_range(0, 9) != 0, 4'($urandom_range(0, 15)), a, $urandom,
               5'($urandom_range(0, 31)), $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      end
      repeat (3) cycle(0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #3;
      chk("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
